// File: rtl/sram_addr_sequencer_if.sv
// -----------------------------------------------------------------------------
// sram_addr_sequencer_if
// Bundles the AVR strobe inputs and the SRAM-side outputs of the
// sram_addr_sequencer so the design and its user share one port list.
//   master : the AVR side / bench; drives the strobes, observes SRAM outputs
//   slave  : the sequencer; consumes strobes, drives SRAM outputs
// Signals:
//   avr_si, avr_sreg_en_n, avr_counter_n, avr_we_n, avr_oe_n, avr_snes_mode
//   sram_addr[ADDR_W], sram_addr_oe, sram_we_n, sram_oe_n, load_err, avr_so
// -----------------------------------------------------------------------------
interface sram_addr_sequencer_if #(
    parameter int ADDR_W = 24
);
    logic              avr_si;
    logic              avr_sreg_en_n;
    logic              avr_counter_n;
    logic              avr_we_n;
    logic              avr_oe_n;
    logic              avr_snes_mode;
    logic [ADDR_W-1:0] sram_addr;
    logic              sram_addr_oe;
    logic              sram_we_n;
    logic              sram_oe_n;
    logic              load_err;
    logic              avr_so;

    modport master (
        output avr_si, avr_sreg_en_n, avr_counter_n, avr_we_n, avr_oe_n, avr_snes_mode,
        input  sram_addr, sram_addr_oe, sram_we_n, sram_oe_n, load_err, avr_so
    );

    modport slave (
        input  avr_si, avr_sreg_en_n, avr_counter_n, avr_we_n, avr_oe_n, avr_snes_mode,
        output sram_addr, sram_addr_oe, sram_we_n, sram_oe_n, load_err, avr_so
    );
endinterface

// File: rtl/sram_addr_sequencer.sv
// -----------------------------------------------------------------------------
// sram_addr_sequencer
// Owns the cartridge SRAM address behind the AVR command decoder:
//   - serially loads a new address (MSB first) while avr_sreg_en_n is low,
//     committing it only if exactly ADDR_W bits arrived (else load_err sets),
//   - post-increments the address by INC_STEP on each sampled falling edge
//     of avr_counter_n while idle,
//   - gates the AVR read/write strobes onto the SRAM and releases the bus
//     while the SNES owns it.
// Ports:
//   avr_clk      single clock, posedge
//   avr_reset_n  asynchronous active-low reset
//   bus          sram_addr_sequencer_if.slave (strobes in, SRAM outputs out)
// Optional feature macro: ADDR_READBACK_EN
//   When defined, the old address is preloaded into the shift register on
//   the first shift edge and streams out on avr_so MSB-first while the new
//   address streams in. When undefined, avr_so is tied low.
// -----------------------------------------------------------------------------
module sram_addr_sequencer #(
    parameter int ADDR_W     = 24,
    parameter int RESET_ADDR = 0,
    parameter int INC_STEP   = 1
) (
    input  logic                  avr_clk,
    input  logic                  avr_reset_n,
    sram_addr_sequencer_if.slave  bus
);
    // bitcnt must hold ADDR_W+1 (saturation marker for an over-long load)
    localparam int CNT_W = $clog2(ADDR_W + 2);
    localparam logic [ADDR_W-1:0] RESET_VAL = ADDR_W'(RESET_ADDR);
    localparam logic [ADDR_W-1:0] STEP_VAL  = ADDR_W'(INC_STEP);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(ADDR_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, SNES} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] sreg_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  bitcnt_q;
    logic              cnt_q;
    logic              addr_oe_q;
    logic              we_n_q;
    logic              oe_n_q;
    logic              load_err_q;
    logic              inc;
    logic              shift_en;
    logic              snes;
    logic              shifting_d;

    assign shift_en   = ~bus.avr_sreg_en_n;
    assign snes       = bus.avr_snes_mode;
    // Falling edge of the counter strobe as seen by two consecutive samples
    assign inc        = cnt_q & ~bus.avr_counter_n;
    // Strobe gating follows the state being entered, so the bus is blocked
    // on the same edge a load begins and released when it ends.
    assign shifting_d = (state_d == SHIFT);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (snes) state_d = SNES;
                     else if (shift_en) state_d = SHIFT;
            SHIFT:   if (snes) state_d = SNES;
                     else if (!shift_en) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            SNES:    if (!snes) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef ADDR_READBACK_EN
    logic so_q;
    assign bus.avr_so = so_q;
`else
    assign bus.avr_so = 1'b0;
`endif

    always_ff @(posedge avr_clk or negedge avr_reset_n) begin
        if (!avr_reset_n) begin
            state_q    <= IDLE;
            sreg_q     <= '0;
            addr_q     <= RESET_VAL;
            bitcnt_q   <= '0;
            cnt_q      <= 1'b1;
            addr_oe_q  <= 1'b0;
            we_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            load_err_q <= 1'b0;
`ifdef ADDR_READBACK_EN
            so_q       <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= bus.avr_counter_n;
            addr_oe_q <= (state_d != SNES);
            // A simultaneous read+write request resolves to a read only
            we_n_q    <= bus.avr_we_n | ~bus.avr_oe_n | snes | shifting_d;
            oe_n_q    <= bus.avr_oe_n | snes | shifting_d;
`ifdef ADDR_READBACK_EN
            so_q      <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (!snes && shift_en) begin
`ifdef ADDR_READBACK_EN
                        // Preload the current address so it shifts out
                        // while the new one shifts in.
                        sreg_q <= {addr_q[ADDR_W-2:0], bus.avr_si};
                        so_q   <= addr_q[ADDR_W-1];
`else
                        sreg_q <= {sreg_q[ADDR_W-2:0], bus.avr_si};
`endif
                        bitcnt_q <= CNT_W'(1);
                    end else if (inc) begin
                        // Shift wins over a coincident strobe; otherwise
                        // post-increment with natural wrap at 2**ADDR_W.
                        addr_q <= addr_q + STEP_VAL;
                    end
                end
                SHIFT: begin
                    if (!snes && shift_en) begin
                        sreg_q <= {sreg_q[ADDR_W-2:0], bus.avr_si};
`ifdef ADDR_READBACK_EN
                        so_q   <= sreg_q[ADDR_W-1];
`endif
                        if (bitcnt_q != CNT_SAT)
                            bitcnt_q <= bitcnt_q + CNT_W'(1);
                    end
                end
                COMMIT: begin
                    if (bitcnt_q == CNT_FULL) begin
                        addr_q     <= sreg_q;
                        load_err_q <= 1'b0;
                    end else begin
                        load_err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sram_addr    = addr_q;
    assign bus.sram_addr_oe = addr_oe_q;
    assign bus.sram_we_n    = we_n_q;
    assign bus.sram_oe_n    = oe_n_q;
    assign bus.load_err     = load_err_q;
endmodule

// File: tb/tb_sram_addr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sram_addr_sequencer
// Directed scenarios with literal expectations followed by randomized traffic.
// A behavioural model (bit queue + address arithmetic) predicts every output;
// one process compares the DUT against it on each falling clock edge.
// -----------------------------------------------------------------------------
module tb_sram_addr_sequencer;
    localparam int W = 24;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sram_addr_sequencer_if #(.ADDR_W(W)) bus_if ();

    sram_addr_sequencer #(
        .ADDR_W    (W),
        .RESET_ADDR(0),
        .INC_STEP  (1)
    ) dut (
        .avr_clk    (clk),
        .avr_reset_n(rst_n),
        .bus        (bus_if)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic checka(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %06h expected %06h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkb(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0, M_LOAD = 1, M_COMMIT = 2, M_SNES = 3;
    int            m_mode;
    bit            m_bits[$];      // bits received in the current load, in order
    logic [W-1:0]  m_addr, m_old;
    bit            m_err, m_cnt_prev;
    logic [W-1:0]  e_addr;
    bit            e_oe, e_we, e_oen, e_err, e_so;

    task automatic model_reset();
        m_mode = M_IDLE; m_bits.delete(); m_addr = '0; m_old = '0;
        m_err = 0; m_cnt_prev = 1;
        e_addr = '0; e_oe = 0; e_we = 1; e_oen = 1; e_err = 0; e_so = 0;
    endtask

    task automatic model_step(input bit si, input bit en_n, input bit ctr_n,
                              input bit we, input bit oe, input bit snes);
        bit inc, loading;
        int k;
        logic [W-1:0] v;
        inc = m_cnt_prev & ~ctr_n;
        m_cnt_prev = ctr_n;
        case (m_mode)
            M_IDLE: begin
                if (!snes && !en_n) begin
                    m_old = m_addr; m_bits.delete(); m_bits.push_back(si); m_mode = M_LOAD;
                end else begin
                    if (inc) m_addr = m_addr + 1;
                    if (snes) m_mode = M_SNES;
                end
            end
            M_LOAD: begin
                if (snes) begin m_bits.delete(); m_mode = M_SNES; end
                else if (!en_n) m_bits.push_back(si);
                else m_mode = M_COMMIT;
            end
            M_COMMIT: begin
                if (m_bits.size() == W) begin
                    v = '0;
                    for (int i = 0; i < W; i++) v = {v[W-2:0], m_bits[i]};
                    m_addr = v; m_err = 0;
                end else m_err = 1;
                m_mode = M_IDLE;
            end
            default: if (!snes) m_mode = M_IDLE;
        endcase
        loading = (m_mode == M_LOAD);
        e_addr = m_addr;
        e_err  = m_err;
        e_oe   = (m_mode != M_SNES);
        e_we   = we | ~oe | snes | loading;
        e_oen  = oe | snes | loading;
        e_so   = 0;
`ifdef ADDR_READBACK_EN
        // Output stream is the old address MSB-first followed by the new bits
        if (loading) begin
            k = m_bits.size();
            e_so = (k <= W) ? m_old[W-k] : m_bits[k-W-1];
        end
`else
        k = 0;
`endif
    endtask

    // Single compare process: outputs settled from the last rising edge;
    // inputs present now are the ones the next rising edge will sample.
    always @(negedge clk) begin
        if (!rst_n) model_reset();
        checka("sram_addr",    bus_if.sram_addr,    e_addr);
        checkb("sram_addr_oe", bus_if.sram_addr_oe, e_oe);
        checkb("sram_we_n",    bus_if.sram_we_n,    e_we);
        checkb("sram_oe_n",    bus_if.sram_oe_n,    e_oen);
        checkb("load_err",     bus_if.load_err,     e_err);
        checkb("avr_so",       bus_if.avr_so,       e_so);
        if (rst_n)
            model_step(bus_if.avr_si, bus_if.avr_sreg_en_n, bus_if.avr_counter_n,
                       bus_if.avr_we_n, bus_if.avr_oe_n, bus_if.avr_snes_mode);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        bus_if.avr_si = 0; bus_if.avr_sreg_en_n = 1; bus_if.avr_counter_n = 1;
        bus_if.avr_we_n = 1; bus_if.avr_oe_n = 1; bus_if.avr_snes_mode = 0;
    endtask

    task automatic shift_bits(input logic [W-1:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bus_if.avr_sreg_en_n = 0; bus_if.avr_si = val[i]; tick();
        end
    endtask

    task automatic load_word(input logic [W-1:0] val, input int n);
        shift_bits(val, n);
        bus_if.avr_sreg_en_n = 1; bus_if.avr_si = 0;
        tick();   // enters COMMIT
        tick();   // COMMIT resolves
    endtask

    task automatic strobe(input logic [W-1:0] exp, input string name);
        bus_if.avr_counter_n = 0; tick();
        checka(name, bus_if.sram_addr, exp);
        bus_if.avr_counter_n = 1; tick();
    endtask

    logic [W-1:0] pat, nxt;

    initial begin
        rst_n = 0;
        idle_inputs();
        repeat (3) tick();
        checka("reset_addr", bus_if.sram_addr, 24'h000000);
        checkb("reset_we_n", bus_if.sram_we_n, 1'b1);
        rst_n = 1;
        tick();
        checkb("idle_addr_oe", bus_if.sram_addr_oe, 1'b1);

        // Full 24-bit load
        load_word(24'h123456, 24);
        checka("load_123456", bus_if.sram_addr, 24'h123456);
        checkb("load_err_clear", bus_if.load_err, 1'b0);

        // Short load keeps the address and flags the error; a good load clears it
        load_word(24'h0F0F0F, 23);
        checka("short_load_addr", bus_if.sram_addr, 24'h123456);
        checkb("short_load_err", bus_if.load_err, 1'b1);
        load_word(24'h00BEEF, 24);
        checka("reload_addr", bus_if.sram_addr, 24'h00BEEF);
        checkb("reload_err", bus_if.load_err, 1'b0);

        // Increment with wrap
        load_word(24'hFFFFFE, 24);
        strobe(24'hFFFFFF, "inc_ffffff");
        strobe(24'h000000, "inc_wrap0");
        strobe(24'h000001, "inc_000001");

        // Strobes during a shift are dropped
        pat = 24'h3C3C3C;
        for (int i = W - 1; i >= 0; i--) begin
            bus_if.avr_sreg_en_n = 0; bus_if.avr_si = pat[i];
            bus_if.avr_counter_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick();
        end
        bus_if.avr_counter_n = 1; bus_if.avr_sreg_en_n = 1;
        tick(); tick();
        checka("no_inc_in_shift", bus_if.sram_addr, 24'h3C3C3C);

        // Old address streams out on avr_so during a new load
        load_word(24'hA5A5A5, 24);
        pat = 24'hA5A5A5;
        nxt = 24'h5A5A5A;
        for (int j = 0; j < W; j++) begin
            bus_if.avr_sreg_en_n = 0; bus_if.avr_si = nxt[W-1-j]; tick();
`ifdef ADDR_READBACK_EN
            checkb("avr_so_readback", bus_if.avr_so, pat[W-1-j]);
`else
            checkb("avr_so_tied", bus_if.avr_so, 1'b0);
`endif
        end
        bus_if.avr_sreg_en_n = 1; tick(); tick();
        checka("readback_load", bus_if.sram_addr, 24'h5A5A5A);

        // SNES takes the bus mid-shift
        shift_bits(24'h000FFF, 10);
        bus_if.avr_snes_mode = 1; bus_if.avr_we_n = 0;
        tick();
        checkb("snes_addr_oe", bus_if.sram_addr_oe, 1'b0);
        checkb("snes_we_n", bus_if.sram_we_n, 1'b1);
        checkb("snes_oe_n", bus_if.sram_oe_n, 1'b1);
        bus_if.avr_snes_mode = 0; bus_if.avr_sreg_en_n = 1;
        tick(); tick();
        checka("snes_addr_kept", bus_if.sram_addr, 24'h5A5A5A);
        checkb("snes_back_oe", bus_if.sram_addr_oe, 1'b1);
        checkb("idle_we_pass", bus_if.sram_we_n, 1'b0);

        // Simultaneous read and write: read wins
        bus_if.avr_oe_n = 0; tick();
        checkb("rw_we_n", bus_if.sram_we_n, 1'b1);
        checkb("rw_oe_n", bus_if.sram_oe_n, 1'b0);
        idle_inputs(); tick();

        // Reset during a shift
        shift_bits(24'h0000AA, 8);
        @(posedge clk); #2;
        rst_n = 0;
        #1;
        checka("midrst_addr", bus_if.sram_addr, 24'h000000);
        checkb("midrst_addr_oe", bus_if.sram_addr_oe, 1'b0);
        idle_inputs(); tick();
        rst_n = 1; tick();

        // Randomized traffic, checked every cycle by the model
        repeat (160) begin
            int r, len;
            r = $urandom_range(0, 9);
            if (r < 4) begin
                len = $urandom_range(20, 27);
                for (int j = 0; j < len; j++) begin
                    bus_if.avr_sreg_en_n = 0;
                    bus_if.avr_si        = 1'($urandom_range(0, 1));
                    bus_if.avr_counter_n = 1'($urandom_range(0, 1));
                    bus_if.avr_we_n      = 1'($urandom_range(0, 1));
                    bus_if.avr_oe_n      = 1'($urandom_range(0, 1));
                    bus_if.avr_snes_mode = ($urandom_range(0, 39) == 0);
                    tick();
                end
                bus_if.avr_sreg_en_n = 1; bus_if.avr_snes_mode = 0; tick();
            end else if (r < 5) begin
                bus_if.avr_snes_mode = 1;
                repeat ($urandom_range(1, 4)) begin
                    bus_if.avr_sreg_en_n = 1'($urandom_range(0, 1));
                    bus_if.avr_counter_n = 1'($urandom_range(0, 1));
                    bus_if.avr_we_n      = 1'($urandom_range(0, 1));
                    bus_if.avr_oe_n      = 1'($urandom_range(0, 1));
                    tick();
                end
                bus_if.avr_snes_mode = 0; bus_if.avr_sreg_en_n = 1; tick();
            end else begin
                repeat ($urandom_range(1, 8)) begin
                    bus_if.avr_sreg_en_n = 1;
                    bus_if.avr_counter_n = 1'($urandom_range(0, 1));
                    bus_if.avr_we_n      = 1'($urandom_range(0, 1));
                    bus_if.avr_oe_n      = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        end
        idle_inputs();
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
